reg_file_19: RTL and testbench

- Architectural register file feeding the ALU operand pair and receiving the ALU result on writeback.
- 8 x 19-bit registers; two combinational read ports (rs -> operand one, rt -> operand two); one synchronous write port.
- Also holds the architectural zero flag, captured from the ALU zero output on flag-setting writebacks.
- Sits between instruction decode and the ALU in the single-cycle datapath.

---
 rtl/reg_file_19.sv | 109 ++++++++++
 tb/tb_reg_file_19.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_19.sv
// reg_file_19: 8 x 19-bit architectural register file with two combinational
// read ports, one synchronous write port, a registered zero flag and a
// saturating count of committed writes.
// Optional feature: define REGFILE_WRITE_BYPASS_EN to forward wr_data to a
// read port in the same cycle when it reads the register being written.

// One combinational read port: storage lookup, optional write-through
// forwarding, and zero-forcing of R0.
module reg_file_19_rd_port #(
  parameter int DATA_W  = 19,
  parameter int ADDR_W  = 3,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] mem,
  input  logic [ADDR_W-1:0]                addr,
  input  logic                             wr_en,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  output logic [DATA_W-1:0]                data
);
  // Select stored value, forward pending write if enabled, force R0 last so
  // a zero-forced R0 never picks up forwarded data.
  always_comb begin
    data = mem[addr];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wr_en && (wr_addr == addr)) data = wr_data;
`endif
    if (R0_ZERO && (addr == '0)) data = '0;
  end

`ifndef REGFILE_WRITE_BYPASS_EN
  // Write-port signals only matter when forwarding is built in.
  logic unused_wr;
  assign unused_wr = wr_en ^ (^wr_addr) ^ (^wr_data);
`endif
endmodule

module reg_file_19 #(
  parameter int DATA_W  = 19,
  parameter int ADDR_W  = 3,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flag_we,
  input  logic              zero_in,
  output logic              zero_flag,
  output logic [7:0]        wr_count
);
  localparam int DEPTH  = 2**ADDR_W;
  localparam int NUM_RD = 2;

  logic [DEPTH-1:0][DATA_W-1:0]  mem;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic                          wr_commit;

  // A write to a zero-forced R0 is dropped entirely, including from the count.
  assign wr_commit = wr_en && !(R0_ZERO && (wr_addr == '0));

  // Register storage; gated by wr_commit so a junk wr_addr with wr_en low
  // cannot disturb any entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem <= '0;
    else if (wr_commit) mem[wr_addr] <= wr_data;
  end

  // Zero flag: reset to 1 to match the all-zero register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zero_flag <= 1'b1;
    else if (flag_we) zero_flag <= zero_in;
  end

  // Committed-write counter, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_count <= '0;
    else if (wr_commit && (wr_count != 8'hFF)) wr_count <= wr_count + 8'd1;
  end

  assign rd_addr = {rt_addr, rs_addr};

  genvar p;
  generate
    for (p = 0; p < NUM_RD; p++) begin : g_rd
      reg_file_19_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .R0_ZERO(R0_ZERO)
      ) u_rd (
        .mem    (mem),
        .addr   (rd_addr[p]),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .data   (rd_data[p])
      );
    end
  endgenerate

  assign rs_data = rd_data[0];
  assign rt_data = rd_data[1];
endmodule

// File: tb/tb_reg_file_19.sv
// Directed bench for reg_file_19 with an array-based reference model and a
// per-cycle compare process on the falling edge.
module tb_reg_file_19;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  rs_addr, rt_addr, wr_addr;
  logic [18:0] rs_data, rt_data, wr_data;
  logic        wr_en, flag_we, zero_in;
  logic        zero_flag;
  logic [7:0]  wr_count;

  int passed = 0;
  int total  = 0;
  bit started = 0;

  // Reference model state.
  logic [18:0] m_reg [8];
  logic        m_flag = 1'b1;
  int          m_cnt  = 0;

  reg_file_19 dut (
    .clk(clk), .rst_n(rst_n),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flag_we(flag_we), .zero_in(zero_in),
    .zero_flag(zero_flag), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Architectural read: R0 is always zero, optionally see the pending write.
  function automatic logic [18:0] exp_rd(input logic [2:0] a);
    if (a == 3'd0) return 19'd0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return m_reg[a];
  endfunction

  // Model update at each edge, cleared whenever reset is low.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 19'd0;
      m_flag = 1'b1;
      m_cnt  = 0;
    end else begin
      if (wr_en && wr_addr != 3'd0) begin
        m_reg[wr_addr] = wr_data;
        if (m_cnt < 255) m_cnt++;
      end
      if (flag_we) m_flag = zero_in;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started && rst_n === 1'b1) begin
      check("rs_data", 32'(rs_data), 32'(exp_rd(rs_addr)));
      check("rt_data", 32'(rt_data), 32'(exp_rd(rt_addr)));
      check("zero_flag", 32'(zero_flag), 32'(m_flag));
      check("wr_count", 32'(wr_count), 32'(m_cnt));
    end
  end

  task automatic drive(input logic we, input logic [2:0] wa, input logic [18:0] wd,
                       input logic fwe, input logic zin, input logic [2:0] ra, input logic [2:0] rb);
    wr_en = we; wr_addr = wa; wr_data = wd; flag_we = fwe; zero_in = zin;
    rs_addr = ra; rt_addr = rb;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #12 rst_n = 1'b1;
    started = 1;
    tick;

    // Build some state, then reset mid-cycle with no clock edge.
    drive(1, 3'd2, 19'h00055, 1, 0, 3'd2, 3'd2);
    tick;
    check("pre_reset_r2", 32'(rs_data), 32'h55);
    check("pre_reset_flag", 32'(zero_flag), 32'h0);
    drive(0, 3'd0, 19'd0, 0, 0, 3'd2, 3'd2);
    #3 rst_n = 1'b0;
    #1;
    check("reset_rs", 32'(rs_data), 32'h0);
    check("reset_flag", 32'(zero_flag), 32'h1);
    check("reset_count", 32'(wr_count), 32'h0);
    #1 rst_n = 1'b1;
    tick;

    // Reset held across an edge with a write pending: write is lost.
    drive(1, 3'd4, 19'h00111, 0, 0, 3'd4, 3'd4);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    drive(0, 3'd0, 19'd0, 0, 0, 3'd4, 3'd4);
    #1 check("reset_wins_r4", 32'(rs_data), 32'h0);
    tick;

    // R3 = all ones, read on both ports.
    drive(1, 3'd3, 19'h7FFFF, 0, 0, 3'd3, 3'd3);
    tick;
    drive(0, 3'd0, 19'd0, 0, 0, 3'd3, 3'd3);
    #1;
    check("r3_rs", 32'(rs_data), 32'h7FFFF);
    check("r3_rt", 32'(rt_data), 32'h7FFFF);
    check("r3_count", 32'(wr_count), 32'd1);
    tick;

    // Write to R0 is discarded.
    drive(1, 3'd0, 19'h12345, 0, 0, 3'd0, 3'd3);
    tick;
    drive(0, 3'd0, 19'd0, 0, 0, 3'd0, 3'd0);
    #1;
    check("r0_zero", 32'(rs_data), 32'h0);
    check("r0_count", 32'(wr_count), 32'd1);
    tick;

    // Same-cycle write/read of R5.
    drive(1, 3'd5, 19'h00ABC, 0, 0, 3'd5, 3'd3);
    #2;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("r5_same_cycle", 32'(rs_data), 32'hABC);
`else
    check("r5_same_cycle", 32'(rs_data), 32'h0);
`endif
    tick;
    drive(0, 3'd0, 19'd0, 0, 0, 3'd5, 3'd3);
    #1 check("r5_next_cycle", 32'(rs_data), 32'hABC);
    tick;

    // Flag capture without a write, then hold.
    drive(0, 3'd0, 19'd0, 1, 0, 3'd5, 3'd3);
    tick;
    check("flag_capture", 32'(zero_flag), 32'h0);
    check("flag_no_write", 32'(wr_count), 32'd2);
    drive(0, 3'd0, 19'd0, 0, 1, 3'd5, 3'd3);
    tick;
    check("flag_hold", 32'(zero_flag), 32'h0);
    drive(0, 3'd0, 19'd0, 1, 1, 3'd5, 3'd3);
    tick;
    check("flag_set", 32'(zero_flag), 32'h1);

    // Junk write address with write disabled.
    drive(0, 3'bx, 19'h7AAAA, 0, 0, 3'd3, 3'd5);
    tick;

    // Mixed pattern across all registers, distinct port addresses.
    for (int i = 0; i < 8; i++) begin
      drive(1, 3'(i), 19'(i * 19'h1357 + 1), (i % 2) == 1, (i % 3) == 0, 3'(i), 3'(7 - i));
      tick;
    end
    drive(0, 3'd0, 19'd0, 0, 0, 3'd6, 3'd7);
    tick;

    // 300 writes to R1: counter sticks at 255, R1 holds last data.
    for (int i = 0; i < 300; i++) begin
      drive(1, 3'd1, 19'(i), 0, 0, 3'd1, 3'd6);
      tick;
    end
    drive(0, 3'd0, 19'd0, 0, 0, 3'd1, 3'd1);
    #1;
    check("sat_count", 32'(wr_count), 32'd255);
    check("sat_r1", 32'(rs_data), 32'd299);
    tick;
    tick;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
